// File: rtl/switch_debouncer_pkg.sv
// Shared types and sizing helpers for the switch debouncer slice.
package switch_debouncer_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    // The fewest flops that still give a usable metastability margin.
    localparam int MIN_SYNC_STAGES = 2;

    // A one-cycle debounce window would not filter anything.
    localparam int MIN_DEBOUNCE_CYCLES = 2;

    // Stability counter width; the counter stops at cycles-1, so $clog2 is enough.
    function automatic int counter_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter, debounced level and edge pulses.
module switch_debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic enable,
    input  logic load,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic update
);

    localparam int CW = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync;
    logic [CW-1:0]          count;

    assign sync = sync_chain[SYNC_STAGES-1];

    // The new level has now persisted for the whole window, so it is accepted this edge.
    assign update = enable && (sync != stable) && (count == TERMINAL);

    // Shift the asynchronous pin through the synchroniser flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the window.
    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (load) begin
                stable <= sync;
                count  <= '0;
            end else if (enable) begin
                if (sync == stable) begin
                    count <= '0;
                end else if (update) begin
                    stable <= sync;
                    count  <= '0;
                    rise   <= sync;
                    fall   <= ~sync;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the board slide switches feeding the SoC switches PIO, with a power-up settle phase.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_valid,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    // Out-of-range parameters are pulled up to the smallest sensible values.
    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam int CYCLES = (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) ? MIN_DEBOUNCE_CYCLES
                                                                     : DEBOUNCE_CYCLES;
    localparam int IW     = $clog2(STAGES + CYCLES);
    localparam logic [IW-1:0] INIT_TERMINAL = IW'(STAGES + CYCLES - 1);

    ctrl_state_t      state;
    logic [IW-1:0]    init_count;
    logic             load;
    logic             enable;
    logic [WIDTH-1:0] update;

    assign load   = (state == INIT) && (init_count == INIT_TERMINAL);
    assign enable = (state == RUN);

    // Settle phase: wait until the synchronisers and one full window have filled, then run forever.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= INIT;
            init_count <= '0;
            sw_valid   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_count <= init_count + 1'b1;
                    if (init_count == INIT_TERMINAL) begin
                        state    <= RUN;
                        sw_valid <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // One summary pulse no matter how many bits are accepted on the same edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |update;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .SYNC_STAGES    (STAGES),
            .DEBOUNCE_CYCLES(CYCLES)
        ) u_bit (
            .clock (clk_clk),
            .reset (reset_reset),
            .raw   (sw_raw[i]),
            .enable(enable),
            .load  (load),
            .stable(sw_stable[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i]),
            .update(update[i])
        );
    end

endmodule
